bram_stack: RTL and testbench

Parametrised LIFO stack held in a single-port synchronous BlockRAM, with a registered valid/ready command and response interface. It supports push, pop, increment-top-in-place and clear, with full/empty/count status and per-response error reporting. It is the generalised successor to the fixed 8-bit-address, 5-bit-data stack under property test: width, depth and backpressure are configurable, and overflow, underflow and clear are handled.

---
 rtl/bram_stack_if.sv | 24 ++
 rtl/bram_stack.sv | 146 ++++++++++++++
 tb/tb_bram_stack.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_stack_if.sv
// Command/response handshake bundle for bram_stack.
// The stack owns the slave side; the driver of commands owns the master side.
interface bram_stack_if #(
   parameter int DATA_WIDTH = 5
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/bram_stack.sv
// LIFO stack in a single-port synchronous RAM with push, pop, increment-top and clear.
// Commands and responses use valid/ready; a response is held until it is consumed.
module bram_stack #(
   parameter int DATA_WIDTH = 5,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   bram_stack_if.slave           bus,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  err_sticky
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {IDLE, READ} state_t;
   typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_INC = 2'b10, OP_CLEAR = 2'b11} op_t;

   state_t                state, state_nxt;
   logic                  inc_pend, inc_nxt;
   logic [ADDR_WIDTH:0]   count_nxt, count_m1;
   logic                  sticky_nxt;
   logic                  accept;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] ram_q, ram_wdata;
   logic [ADDR_WIDTH-1:0] ram_addr, top_addr;
   logic                  ram_we;

   logic                  rsp_valid, rsp_err, rsp_load, rsp_err_nxt;
   logic [DATA_WIDTH-1:0] rsp_data, rsp_data_nxt;

   function automatic logic [DATA_WIDTH-1:0] incr_wrap(input logic [DATA_WIDTH-1:0] v);
      return v + DATA_WIDTH'(1);
   endfunction

   assign count_m1      = count - (ADDR_WIDTH+1)'(1);
   assign top_addr      = count_m1[ADDR_WIDTH-1:0];
   assign empty         = (count == '0);
   assign full          = (count == (ADDR_WIDTH+1)'(DEPTH));
   assign bus.cmd_ready = (state == IDLE) && (!rsp_valid || bus.rsp_ready);
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data;
   assign bus.rsp_err   = rsp_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      sticky_nxt   = err_sticky;
      inc_nxt      = inc_pend;
      ram_we       = 1'b0;
      ram_addr     = top_addr;
      ram_wdata    = bus.cmd_data;
      rsp_load     = 1'b0;
      rsp_data_nxt = '0;
      rsp_err_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               rsp_load = 1'b1;
               case (op_t'(bus.cmd_op))
                  OP_PUSH: begin
                     if (!full) begin
                        ram_we       = 1'b1;
                        ram_addr     = count[ADDR_WIDTH-1:0];
                        count_nxt    = count + (ADDR_WIDTH+1)'(1);
                        rsp_data_nxt = bus.cmd_data;
                     end else begin
                        rsp_err_nxt = 1'b1;
                        sticky_nxt  = 1'b1;
                     end
                  end
                  OP_POP, OP_INC: begin
                     // The read of the top entry is issued now; the response waits for READ.
                     if (!empty) begin
                        rsp_load  = 1'b0;
                        state_nxt = READ;
                        inc_nxt   = (op_t'(bus.cmd_op) == OP_INC);
                     end else begin
                        rsp_err_nxt = 1'b1;
                        sticky_nxt  = 1'b1;
                     end
                  end
                  OP_CLEAR: begin
                     count_nxt  = '0;
                     sticky_nxt = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         READ: begin
            state_nxt = IDLE;
            rsp_load  = 1'b1;
            if (inc_pend) begin
               ram_we       = 1'b1;
               ram_wdata    = incr_wrap(ram_q);
               rsp_data_nxt = incr_wrap(ram_q);
            end else begin
               count_nxt    = count_m1;
               rsp_data_nxt = ram_q;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count      <= '0;
         err_sticky <= 1'b0;
         inc_pend   <= 1'b0;
      end else begin
         count      <= count_nxt;
         err_sticky <= sticky_nxt;
         inc_pend   <= inc_nxt;
      end
   end

   // Response register: loaded only when empty or draining this edge, so nothing is overwritten.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (rsp_load) begin
         rsp_valid <= 1'b1;
         rsp_data  <= rsp_data_nxt;
         rsp_err   <= rsp_err_nxt;
      end else if (rsp_valid && bus.rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
   end
endmodule

// File: tb/tb_bram_stack.sv
// Randomised and directed bench for bram_stack with a queue-based reference stack and scoreboard.
module tb_bram_stack;
   localparam int DW = 5;
   localparam int AW = 3;
   localparam int DEPTH = 2 ** AW;

   typedef struct {
      int data;
      int err;
      int cnt;
      int sticky;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [AW:0] count;
   logic empty, full, err_sticky;
   int n_tests = 0;
   int n_fail  = 0;
   int rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

   int   stk[$];
   int   m_sticky = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   bram_stack_if #(.DATA_WIDTH(DW)) bus ();

   bram_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .count(count), .empty(empty), .full(full), .err_sticky(err_sticky)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain queue used as a stack, updated at each accepted command.
   function automatic void model_accept(input int op, input int d);
      exp_t e;
      e.data = 0;
      e.err  = 0;
      case (op)
         0: if (stk.size() < DEPTH) begin stk.push_back(d); e.data = d; end
            else begin e.err = 1; m_sticky = 1; end
         1: if (stk.size() > 0) e.data = stk.pop_back();
            else begin e.err = 1; m_sticky = 1; end
         2: if (stk.size() > 0) begin
               e.data = (stk[stk.size()-1] + 1) % (1 << DW);
               stk[stk.size()-1] = e.data;
            end else begin e.err = 1; m_sticky = 1; end
         default: begin stk.delete(); m_sticky = 0; end
      endcase
      e.cnt    = stk.size();
      e.sticky = m_sticky;
      exp_q.push_back(e);
   endfunction

   task automatic issue(input int op, input int d, output int waited);
      waited = 0;
      bus.cmd_op    = 2'(op);
      bus.cmd_data  = DW'(d);
      bus.cmd_valid = 1'b1;
      @(negedge clock);
      while (!bus.cmd_ready) begin
         waited++;
         if (waited > 200) begin
            chk("cmd_accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
         end
         @(negedge clock);
      end
      @(posedge clock);
      model_accept(op, d);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic do_op(input int op, input int d);
      int w;
      issue(op, d, w);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clock);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      @(posedge clock);
      #1;
   endtask

   always @(posedge clock) begin
      #2;
      case (rdy_mode)
         0:       bus.rsp_ready = 1'b1;
         1:       bus.rsp_ready = 1'b0;
         default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clock) begin
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_data", int'(bus.rsp_data), mon_e.data);
            chk("rsp_err", int'(bus.rsp_err), mon_e.err);
            chk("rsp_count", int'(count), mon_e.cnt);
            chk("rsp_sticky", int'(err_sticky), mon_e.sticky);
         end
      end
   end

   initial begin
      int w, r, op;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = '0;
      #2 reset = 1'b1;
      #20;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_rsp_data", int'(bus.rsp_data), 0);
      chk("rst_rsp_err", int'(bus.rsp_err), 0);
      chk("rst_sticky", int'(err_sticky), 0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Basic LIFO order and underflow
      do_op(0, 3); do_op(0, 7); do_op(0, 9);
      do_op(1, 0); do_op(1, 0); do_op(1, 0);
      do_op(1, 0);
      wait_drain();
      chk("underflow_sticky", int'(err_sticky), 1);

      // Fill to depth, reject overflow, pop top
      do_op(3, 0);
      for (int i = 0; i < DEPTH; i++) do_op(0, i);
      wait_drain();
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), DEPTH);
      do_op(0, 9);
      do_op(1, 0);
      wait_drain();

      // Increment wraps all-ones to zero and writes back
      do_op(3, 0);
      do_op(0, 31); do_op(2, 0); do_op(1, 0);
      wait_drain();

      // Backpressure: response held, commands blocked
      rdy_mode = 1;
      do_op(0, 5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("stall_cmd_ready", int'(bus.cmd_ready), 0);
         chk("stall_rsp_valid", int'(bus.rsp_valid), 1);
         chk("stall_rsp_data", int'(bus.rsp_data), 5);
      end
      @(posedge clock);
      #1 rdy_mode = 0;
      issue(1, 0, w);
      chk("release_same_edge", w, 0);
      wait_drain();

      // Reset while a pop is in READ
      do_op(0, 6); do_op(0, 2);
      wait_drain();
      do_op(1, 0);
      reset = 1'b1;
      exp_q.delete();
      stk.delete();
      m_sticky = 0;
      @(posedge clock);
      #1 reset = 1'b0;
      chk("rdrst_count", int'(count), 0);
      chk("rdrst_rsp_valid", int'(bus.rsp_valid), 0);
      do_op(0, 4); do_op(1, 0);
      wait_drain();

      // Underflow then clear
      do_op(2, 0);
      wait_drain();
      chk("uf_sticky", int'(err_sticky), 1);
      do_op(3, 0);
      wait_drain();
      chk("clr_sticky", int'(err_sticky), 0);

      // Random traffic with random backpressure
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 99);
         op = (r < 42) ? 0 : (r < 70) ? 1 : (r < 94) ? 2 : 3;
         do_op(op, $urandom_range(0, 31));
      end
      rdy_mode = 0;
      wait_drain();
      chk("final_count", int'(count), stk.size());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
